// File: rtl/id_ex_stage_if.sv
// ID/EX stage signal bundle: ID-side fields, EX/MEM and MEM/WB forwarding sources, EX outputs.
// The slave modport is the stage itself; the master modport is whoever drives ID and consumes EX.
interface id_ex_stage_if #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
);
  logic               stall;
  logic               flush;
  logic               id_valid;
  logic [WIDTH-1:0]   id_rd1;
  logic [WIDTH-1:0]   id_rd2;
  logic [WIDTH-1:0]   id_signimm;
  logic [4:0]         id_shamt;
  logic [2:0]         id_alucontrol;
  logic               id_alusrc;
  logic               id_regdst;
  logic               id_regwrite;
  logic               id_memwrite;
  logic               id_memtoreg;
  logic [REGBITS-1:0] id_rs;
  logic [REGBITS-1:0] id_rt;
  logic [REGBITS-1:0] id_rd;
  logic               mem_regwrite;
  logic [REGBITS-1:0] mem_writereg;
  logic [WIDTH-1:0]   mem_aluout;
  logic               wb_regwrite;
  logic [REGBITS-1:0] wb_writereg;
  logic [WIDTH-1:0]   wb_result;
  logic [WIDTH-1:0]   ex_srca;
  logic [WIDTH-1:0]   ex_srcb;
  logic [4:0]         ex_shamt;
  logic [2:0]         ex_alucontrol;
  logic [WIDTH-1:0]   ex_writedata;
  logic [REGBITS-1:0] ex_writereg;
  logic               ex_regwrite;
  logic               ex_memwrite;
  logic               ex_memtoreg;
  logic [REGBITS-1:0] ex_rs;
  logic [REGBITS-1:0] ex_rt;
  logic               ex_valid;

  modport slave (
    input  stall, flush, id_valid, id_rd1, id_rd2, id_signimm, id_shamt, id_alucontrol,
           id_alusrc, id_regdst, id_regwrite, id_memwrite, id_memtoreg, id_rs, id_rt, id_rd,
           mem_regwrite, mem_writereg, mem_aluout, wb_regwrite, wb_writereg, wb_result,
    output ex_srca, ex_srcb, ex_shamt, ex_alucontrol, ex_writedata, ex_writereg,
           ex_regwrite, ex_memwrite, ex_memtoreg, ex_rs, ex_rt, ex_valid
  );

  modport master (
    output stall, flush, id_valid, id_rd1, id_rd2, id_signimm, id_shamt, id_alucontrol,
           id_alusrc, id_regdst, id_regwrite, id_memwrite, id_memtoreg, id_rs, id_rt, id_rd,
           mem_regwrite, mem_writereg, mem_aluout, wb_regwrite, wb_writereg, wb_result,
    input  ex_srca, ex_srcb, ex_shamt, ex_alucontrol, ex_writedata, ex_writereg,
           ex_regwrite, ex_memwrite, ex_memtoreg, ex_rs, ex_rt, ex_valid
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX operand forwarding; 1-cycle capture latency, forwarding is combinational.
// Backpressure: stall holds every register, flush (dominant) or an invalid ID slot loads a bubble.
module id_ex_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               memwrite;
    logic               memtoreg;
    logic               alusrc;
    logic [2:0]         alucontrol;
    logic [4:0]         shamt;
    logic [WIDTH-1:0]   rd1;
    logic [WIDTH-1:0]   rd2;
    logic [WIDTH-1:0]   signimm;
    logic [REGBITS-1:0] rs;
    logic [REGBITS-1:0] rt;
    logic [REGBITS-1:0] writereg;
  } stage_t;

  stage_t           r_stage;
  stage_t           w_load;
  logic [WIDTH-1:0] w_fwd_a;
  logic [WIDTH-1:0] w_fwd_b;

  // An empty ID slot captures as an all-zero bubble, same as a flush.
  always_comb begin
    w_load = '0;
    if (bus.id_valid) begin
      w_load.valid      = 1'b1;
      w_load.regwrite   = bus.id_regwrite;
      w_load.memwrite   = bus.id_memwrite;
      w_load.memtoreg   = bus.id_memtoreg;
      w_load.alusrc     = bus.id_alusrc;
      w_load.alucontrol = bus.id_alucontrol;
      w_load.shamt      = bus.id_shamt;
      w_load.rd1        = bus.id_rd1;
      w_load.rd2        = bus.id_rd2;
      w_load.signimm    = bus.id_signimm;
      w_load.rs         = bus.id_rs;
      w_load.rt         = bus.id_rt;
      w_load.writereg   = bus.id_regdst ? bus.id_rd : bus.id_rt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stage <= '0;
    end else if (bus.flush) begin
      r_stage <= '0;
    end else if (!bus.stall) begin
      r_stage <= w_load;
    end
  end

  // MEM is the younger producer, so it wins over WB; register 0 is never forwarded.
  always_comb begin
    w_fwd_a = r_stage.rd1;
    if (bus.mem_regwrite && (bus.mem_writereg != '0) && (bus.mem_writereg == r_stage.rs)) begin
      w_fwd_a = bus.mem_aluout;
    end else if (bus.wb_regwrite && (bus.wb_writereg != '0) && (bus.wb_writereg == r_stage.rs)) begin
      w_fwd_a = bus.wb_result;
    end
  end

  always_comb begin
    w_fwd_b = r_stage.rd2;
    if (bus.mem_regwrite && (bus.mem_writereg != '0) && (bus.mem_writereg == r_stage.rt)) begin
      w_fwd_b = bus.mem_aluout;
    end else if (bus.wb_regwrite && (bus.wb_writereg != '0) && (bus.wb_writereg == r_stage.rt)) begin
      w_fwd_b = bus.wb_result;
    end
  end

  assign bus.ex_srca       = w_fwd_a;
  assign bus.ex_writedata  = w_fwd_b;
  assign bus.ex_srcb       = r_stage.alusrc ? r_stage.signimm : w_fwd_b;
  assign bus.ex_shamt      = r_stage.shamt;
  assign bus.ex_alucontrol = r_stage.alucontrol;
  assign bus.ex_writereg   = r_stage.writereg;
  assign bus.ex_regwrite   = r_stage.valid & r_stage.regwrite;
  assign bus.ex_memwrite   = r_stage.valid & r_stage.memwrite;
  assign bus.ex_memtoreg   = r_stage.valid & r_stage.memtoreg;
  assign bus.ex_rs         = r_stage.rs;
  assign bus.ex_rt         = r_stage.rt;
  assign bus.ex_valid      = r_stage.valid;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed plus randomized bench for id_ex_stage against a cycle-level reference of the stage contents.
module tb_id_ex_stage;
  localparam int W  = 32;
  localparam int RB = 5;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  id_ex_stage_if #(.WIDTH(W), .REGBITS(RB)) bus ();
  id_ex_stage #(.WIDTH(W), .REGBITS(RB)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  // What the EX stage is expected to hold: the instruction last accepted from ID.
  typedef struct {
    bit        valid, rw, mw, mtr, alusrc;
    bit [2:0]  aluc;
    bit [4:0]  shamt;
    bit [31:0] rd1, rd2, imm;
    bit [4:0]  rs, rt, wr;
  } model_t;

  model_t m;

  function automatic model_t bubble();
    model_t z;
    z = '{default: 0};
    return z;
  endfunction

  function automatic model_t next_m();
    model_t n;
    if (bus.flush) return bubble();
    if (bus.stall) return m;
    if (!bus.id_valid) return bubble();
    n.valid  = 1'b1;
    n.rw     = bus.id_regwrite;
    n.mw     = bus.id_memwrite;
    n.mtr    = bus.id_memtoreg;
    n.alusrc = bus.id_alusrc;
    n.aluc   = bus.id_alucontrol;
    n.shamt  = bus.id_shamt;
    n.rd1    = bus.id_rd1;
    n.rd2    = bus.id_rd2;
    n.imm    = bus.id_signimm;
    n.rs     = bus.id_rs;
    n.rt     = bus.id_rt;
    n.wr     = bus.id_regdst ? bus.id_rd : bus.id_rt;
    return n;
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] cap);
    if (r == 5'd0) return cap;
    if (bus.mem_regwrite && bus.mem_writereg == r) return bus.mem_aluout;
    if (bus.wb_regwrite && bus.wb_writereg == r) return bus.wb_result;
    return cap;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] a, b;
    a = fwd(m.rs, m.rd1);
    b = fwd(m.rt, m.rd2);
    chk({tag, ".srca"},      bus.ex_srca, a);
    chk({tag, ".srcb"},      bus.ex_srcb, m.alusrc ? m.imm : b);
    chk({tag, ".writedata"}, bus.ex_writedata, b);
    chk({tag, ".shamt"},     32'(bus.ex_shamt), 32'(m.shamt));
    chk({tag, ".aluc"},      32'(bus.ex_alucontrol), 32'(m.aluc));
    chk({tag, ".writereg"},  32'(bus.ex_writereg), 32'(m.wr));
    chk({tag, ".regwrite"},  32'(bus.ex_regwrite), 32'(m.valid & m.rw));
    chk({tag, ".memwrite"},  32'(bus.ex_memwrite), 32'(m.valid & m.mw));
    chk({tag, ".memtoreg"},  32'(bus.ex_memtoreg), 32'(m.valid & m.mtr));
    chk({tag, ".rs"},        32'(bus.ex_rs), 32'(m.rs));
    chk({tag, ".rt"},        32'(bus.ex_rt), 32'(m.rt));
    chk({tag, ".valid"},     32'(bus.ex_valid), 32'(m.valid));
  endtask

  task automatic tick();
    model_t n;
    n = next_m();
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic load(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                      input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                      input logic [2:0] aluc, input logic alusrc, input logic regdst,
                      input logic rw, input logic mw, input logic mtr);
    bus.id_valid = 1'b1; bus.stall = 1'b0; bus.flush = 1'b0;
    bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_rd1 = rd1; bus.id_rd2 = rd2; bus.id_signimm = imm;
    bus.id_alucontrol = aluc; bus.id_shamt = 5'd0;
    bus.id_alusrc = alusrc; bus.id_regdst = regdst;
    bus.id_regwrite = rw; bus.id_memwrite = mw; bus.id_memtoreg = mtr;
  endtask

  task automatic fwd_off();
    bus.mem_regwrite = 1'b0; bus.mem_writereg = '0; bus.mem_aluout = '0;
    bus.wb_regwrite = 1'b0; bus.wb_writereg = '0; bus.wb_result = '0;
  endtask

  task automatic rand_id();
    bus.id_valid = ($urandom_range(0, 3) != 0);
    bus.id_rd1 = $urandom; bus.id_rd2 = $urandom; bus.id_signimm = $urandom;
    bus.id_shamt = 5'($urandom_range(0, 31)); bus.id_alucontrol = 3'($urandom_range(0, 7));
    bus.id_alusrc = 1'($urandom_range(0, 1)); bus.id_regdst = 1'($urandom_range(0, 1));
    bus.id_regwrite = 1'($urandom_range(0, 1)); bus.id_memwrite = 1'($urandom_range(0, 1));
    bus.id_memtoreg = 1'($urandom_range(0, 1));
    bus.id_rs = 5'($urandom_range(0, 3)); bus.id_rt = 5'($urandom_range(0, 3));
    bus.id_rd = 5'($urandom_range(0, 31));
  endtask

  task automatic rand_fwd();
    bus.mem_regwrite = 1'($urandom_range(0, 1)); bus.mem_writereg = 5'($urandom_range(0, 3));
    bus.mem_aluout = $urandom;
    bus.wb_regwrite = 1'($urandom_range(0, 1)); bus.wb_writereg = 5'($urandom_range(0, 3));
    bus.wb_result = $urandom;
  endtask

  initial begin
    m = bubble();
    load(5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.id_valid = 1'b0;
    fwd_off();
    #1 reset_n = 1'b0;
    #2 check_all("reset");
    @(posedge clk); #2;
    reset_n = 1'b1;

    // T2: plain add, writereg taken from rd
    load(5'd8, 5'd9, 5'd10, 32'd5, 32'd7, 32'h0, 3'b010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    check_all("t2");
    chk("t2.srca_const", bus.ex_srca, 32'd5);
    chk("t2.srcb_const", bus.ex_srcb, 32'd7);
    chk("t2.writereg_const", 32'(bus.ex_writereg), 32'd10);
    chk("t2.regwrite_const", 32'(bus.ex_regwrite), 32'd1);

    // T3: MEM over WB, then WB alone, then register 0 never forwards
    bus.mem_regwrite = 1'b1; bus.mem_writereg = 5'd8; bus.mem_aluout = 32'h11;
    bus.wb_regwrite = 1'b1; bus.wb_writereg = 5'd8; bus.wb_result = 32'h22;
    #1 chk("t3.mem_wins", bus.ex_srca, 32'h11);
    bus.mem_regwrite = 1'b0;
    #1 chk("t3.wb_only", bus.ex_srca, 32'h22);
    bus.mem_regwrite = 1'b1; bus.mem_writereg = 5'd0; bus.wb_writereg = 5'd0;
    #1 chk("t3.reg0", bus.ex_srca, 32'd5);
    check_all("t3");

    // T4: immediate operand with store data forwarded from MEM
    fwd_off();
    load(5'd3, 5'd4, 5'd6, 32'd1, 32'd2, 32'hFFFF_FFFC, 3'b010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    bus.mem_regwrite = 1'b1; bus.mem_writereg = 5'd4; bus.mem_aluout = 32'h33;
    #1 chk("t4.srcb_imm", bus.ex_srcb, 32'hFFFF_FFFC);
    chk("t4.writedata", bus.ex_writedata, 32'h33);
    chk("t4.writereg", 32'(bus.ex_writereg), 32'd4);
    check_all("t4");

    // T1: asynchronous reset between edges
    #1 reset_n = 1'b0;
    m = bubble();
    #1 check_all("t1");
    chk("t1.valid", 32'(bus.ex_valid), 32'd0);
    chk("t1.srcb", bus.ex_srcb, 32'd0);
    #1 reset_n = 1'b1;

    // T5: stall holds through changing ID, then flush beats stall
    fwd_off();
    load(5'd1, 5'd2, 5'd3, 32'hA1, 32'hB2, 32'h0, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_id();
      tick();
      check_all("t5.stall");
      chk("t5.hold_writereg", 32'(bus.ex_writereg), 32'd3);
      chk("t5.hold_srca", bus.ex_srca, 32'hA1);
    end
    bus.flush = 1'b1;
    tick();
    chk("t5.flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("t5.flush_regwrite", 32'(bus.ex_regwrite), 32'd0);
    check_all("t5.flush");

    // T6: load then flush on the following edge
    load(5'd5, 5'd6, 5'd7, 32'h55, 32'h66, 32'h0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_all("t6.load");
    bus.flush = 1'b1;
    bus.mem_regwrite = 1'b1; bus.mem_writereg = 5'd5; bus.mem_aluout = 32'h77;
    tick();
    chk("t6.valid", 32'(bus.ex_valid), 32'd0);
    chk("t6.memwrite", 32'(bus.ex_memwrite), 32'd0);
    chk("t6.rs", 32'(bus.ex_rs), 32'd0);
    chk("t6.rt", 32'(bus.ex_rt), 32'd0);
    chk("t6.srca", bus.ex_srca, 32'd0);
    check_all("t6");

    // Randomized traffic; forwarding sources also change between edges
    for (int i = 0; i < 300; i++) begin
      rand_id();
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.flush = ($urandom_range(0, 7) == 0);
      rand_fwd();
      tick();
      check_all("rand.edge");
      rand_fwd();
      #1 check_all("rand.fwd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
